// File: rtl/ascii_cmd_to_adxl362_regs_if.sv
// Byte-stream input, register-command output and status signals of the ASCII
// command parser. The parser uses the slave modport and its peer uses master.
interface ascii_cmd_to_adxl362_regs_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       o_rx_ready;
    logic       o_cmd_valid;
    logic       i_cmd_ready;
    logic       o_cmd_write;
    logic [7:0] o_cmd_addr;
    logic [7:0] o_cmd_data;
    logic       o_err_pulse;
    logic [1:0] o_err_code;
    logic       o_busy;

    modport slave (
        input  i_rx_valid, i_rx_data, i_cmd_ready,
        output o_rx_ready, o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_data,
        output o_err_pulse, o_err_code, o_busy
    );

    modport master (
        output i_rx_valid, i_rx_data, i_cmd_ready,
        input  o_rx_ready, o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_data,
        input  o_err_pulse, o_err_code, o_busy
    );
endinterface

// File: rtl/ascii_cmd_to_adxl362_regs.sv
// Parses "Waadd<CR>" / "Raa<CR>" ASCII lines into ADXL362 register read/write
// commands, with error reporting and an inactivity timeout for partial lines.
module ascii_cmd_to_adxl362_regs #(
    parameter int unsigned p_idle_timeout_cycles = 20000000
) (
    input logic                        i_clk_20mhz,
    input logic                        i_rst_20mhz,
    ascii_cmd_to_adxl362_regs_if.slave bus
);

    localparam int unsigned cnt_w =
        (p_idle_timeout_cycles > 1) ? $clog2(p_idle_timeout_cycles) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(p_idle_timeout_cycles - 1);

    localparam logic [7:0] ch_cr   = 8'h0D;
    localparam logic [7:0] ch_lf   = 8'h0A;
    localparam logic [7:0] ch_w_up = 8'h57;
    localparam logic [7:0] ch_w_lo = 8'h77;
    localparam logic [7:0] ch_r_up = 8'h52;
    localparam logic [7:0] ch_r_lo = 8'h72;

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StDataHi,
        StDataLo,
        StWaitCr,
        StIssue,
        StDiscard
    } state_e;

    state_e           state_q, state_d;
    logic             write_q, write_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;

    logic       consume;
    logic       timeout;
    logic       is_cr;
    logic       is_hex;
    logic [3:0] nibble;

    assign consume = bus.i_rx_valid && bus.o_rx_ready;
    assign timeout = (cnt_q == cnt_max);
    assign is_cr   = (bus.i_rx_data == ch_cr);

    // Letters carry their value in the low nibble offset by 9 ('A' = 0x41, 'a' = 0x61).
    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        if (bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h39) begin
            nibble = bus.i_rx_data[3:0];
        end else if ((bus.i_rx_data >= 8'h41 && bus.i_rx_data <= 8'h46) ||
                     (bus.i_rx_data >= 8'h61 && bus.i_rx_data <= 8'h66)) begin
            nibble = bus.i_rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        cnt_d       = cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (consume) begin
                    if (bus.i_rx_data == ch_w_up || bus.i_rx_data == ch_w_lo) begin
                        write_d = 1'b1;
                        state_d = StAddrHi;
                    end else if (bus.i_rx_data == ch_r_up || bus.i_rx_data == ch_r_lo) begin
                        write_d = 1'b0;
                        state_d = StAddrHi;
                    end else if (!is_cr && bus.i_rx_data != ch_lf) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = StDiscard;
                    end
                end
            end
            StAddrHi, StAddrLo, StDataHi, StDataLo: begin
                if (consume) begin
                    if (is_cr) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = StIdle;
                    end else if (!is_hex) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = StDiscard;
                    end else begin
                        unique case (state_q)
                            StAddrHi: begin
                                addr_d  = {addr_q[3:0], nibble};
                                state_d = StAddrLo;
                            end
                            StAddrLo: begin
                                addr_d  = {addr_q[3:0], nibble};
                                state_d = write_q ? StDataHi : StWaitCr;
                            end
                            StDataHi: begin
                                data_d  = {data_q[3:0], nibble};
                                state_d = StDataLo;
                            end
                            default: begin
                                data_d  = {data_q[3:0], nibble};
                                state_d = StWaitCr;
                            end
                        endcase
                    end
                end else if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = StIdle;
                end
            end
            StWaitCr: begin
                if (consume) begin
                    if (is_cr) begin
                        state_d = StIssue;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = StDiscard;
                    end
                end else if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'd3;
                    state_d     = StIdle;
                end
            end
            StIssue: begin
                if (bus.i_cmd_ready) begin
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if ((consume && is_cr) || (!consume && timeout)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A consumed byte always wins over a timeout reached on the same cycle.
        if (consume || timeout || state_q == StIdle || state_q == StIssue) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.o_cmd_valid = (state_q == StIssue);
    assign bus.o_cmd_write = write_q;
    assign bus.o_cmd_addr  = addr_q;
    assign bus.o_cmd_data  = write_q ? data_q : 8'h00;
    assign bus.o_err_pulse = err_pulse_q;
    assign bus.o_err_code  = err_code_q;
    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_rx_ready  = (state_q != StIssue);

endmodule
